parity_splitter: RTL and testbench
==================================

# parity_splitter

Parametrised word-to-chunk serialiser with per-chunk parity. Accepts a `DATA_W`-bit word over a valid/ready handshake and emits it as `DATA_W/CHUNK_W` chunks. Each chunk carries its parity bit, is sent MSB-first or LSB-first, and obeys output backpressure. It sits between a word-wide producer and a narrow parity-protected link. It supersedes the fixed 32-bit/4-byte start-pulse splitter: the widths, parity sense and order are parameters, it has a real valid/ready handshake, and it accepts back-to-back words with no idle cycle.

## Interface
- `DATA_W`, 32, input word width; must be an integer multiple of `CHUNK_W`.
- `CHUNK_W`, 8, chunk width; `NCHUNK = DATA_W/CHUNK_W` must be ≥ 2.
- `ODD_PARITY`, 0, parity sense: 0 = even (parity bit = XOR of chunk), 1 = odd (parity bit = inverted XOR).
- `LSB_FIRST`, 0, chunk order: 0 = most-significant chunk first, 1 = least-significant chunk first.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_W  word to split.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `out_data`  out  CHUNK_W+1  `{parity, chunk}`.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer takes `out_data` this cycle.
- `out_idx`  out  clog2(NCHUNK)  position of the current chunk in send order, starting at 0.
- `out_last`  out  1  current chunk is the final chunk of the word.
- `done`  out  1  one-cycle pulse after the last chunk of a word is accepted.

## Operation
- FSM has two states.
  - IDLE: `in_ready`=1. An input handshake (`in_valid && in_ready`) loads the word into the shift register, clears `idx`, and moves to SEND.
  - SEND: `out_valid`=1. Each output handshake (`out_valid && out_ready`) advances the shift register by `CHUNK_W` and increments `idx`.
- Handshake on the last chunk:
  - If `in_valid` is also high, the FSM loads the next word and stays in SEND.
  - Otherwise it returns to IDLE.
- `in_ready` = IDLE, or (SEND && `out_last` && `out_ready`). This combinational path from `out_ready` to `in_ready` is what allows zero-bubble streaming.
- Chunk order:
  - `LSB_FIRST`=0: chunk k = `in_data[DATA_W-1-k*CHUNK_W -: CHUNK_W]`.
  - `LSB_FIRST`=1: chunk k = `in_data[k*CHUNK_W +: CHUNK_W]`.
- Parity is computed combinationally from the shift-register head, so `out_data` always reflects the stored word.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_idx` and `out_last` hold stable. `in_valid` is ignored in this condition.
- `out_last` = (`idx` == NCHUNK-1) && `out_valid`.
- Illegal parameters (`DATA_W % CHUNK_W != 0` or NCHUNK < 2) cause an elaboration error.

## Timing
- Reset (`rst`=0) takes effect asynchronously:
  - FSM goes to IDLE; the shift register and `idx` clear to 0.
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `done`=0.
  - `in_ready`=1 once `rst` is deasserted.
- Reset during SEND discards the word in progress. After release, the next accepted word starts at chunk 0.
- Latency: an input handshake at edge k gives chunk 0 valid from edge k+1. With `out_ready` held at 1, a word occupies exactly NCHUNK cycles.
- Sustained throughput is 1 chunk per cycle across word boundaries, with no idle cycle between words.
- `done` rises at the edge after the last-chunk handshake and lasts 1 cycle. It also pulses when a new word loads on that same edge.
- `idx` wraps from NCHUNK-1 to 0 only on a last-chunk handshake.

## Structure
- `parity_pkg` holds:
  - the state encoding localparams (IDLE, SEND);
  - a `clog2` function;
  - a `chunk_count(DATA_W, CHUNK_W)` function.
- Sub-module `parity_chunk`: combinational; inputs `CHUNK_W` data and `ODD_PARITY`; output the 1-bit parity.
- The top level contains the FSM, the shift register, the index counter and the `done` register.

## Test plan
- Even parity, MSB-first: `in_data`=0x12345678, `out_ready`=1 → `out_data` = 0x012, 0x134, 0x056, 0x078 on consecutive cycles; `out_last` on the 4th beat; `done` 1 cycle later.
- `ODD_PARITY`=1, same word → 0x112, 0x034, 0x156, 0x178.
- `LSB_FIRST`=1, even parity, same word → 0x078, 0x056, 0x134, 0x012; `out_idx` = 0, 1, 2, 3.
- Backpressure: hold `out_ready`=0 for 3 cycles while chunk 1 is presented → `out_data` stays 0x134 and `out_idx` stays 1; `in_ready`=0 even with `in_valid`=1.
- Back-to-back: words 0x12345678 then 0xFFFF0000, `in_valid` held high, `out_ready`=1 → 8 consecutive valid beats with no gap (…, 0x078, 0x0FF, 0x0FF, 0x000, 0x000); `done` pulses twice.
- Reset mid-word: assert `rst`=0 after 2 chunks are accepted → `out_valid`=0 immediately. After release, word 0xA5A5A5A5 produces 0x0A5 ×4 starting at `out_idx`=0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and elaboration helpers for the parity splitter.
`default_nettype none

package parity_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int chunk_count(input int data_w, input int chunk_w);
    return data_w / chunk_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/parity_splitter_if.sv
// Word-in / chunk-out handshake bundle; master drives words in and takes chunks out.
`default_nettype none

interface parity_splitter_if
  import parity_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
);

  localparam int NCHUNK = chunk_count(DATA_W, CHUNK_W);
  localparam int IDX_W  = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);

  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [CHUNK_W:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic               done;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_idx, out_last, done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_idx, out_last, done
  );

endinterface

`default_nettype wire

// File: rtl/parity_chunk.sv
// Single-chunk parity generator: even parity is the XOR of the bits, odd is its inverse.
`default_nettype none

module parity_chunk #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] data,
  input  logic               odd_parity,
  output logic               parity
);

  assign parity = (^data) ^ odd_parity;

endmodule

`default_nettype wire

// File: rtl/parity_splitter.sv
// Serialises a DATA_W word into NCHUNK parity-tagged chunks over valid/ready handshakes.
`default_nettype none

module parity_splitter
  import parity_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CHUNK_W    = 8,
  parameter int ODD_PARITY = 0,
  parameter int LSB_FIRST  = 0
) (
  input  logic              clk,
  input  logic              rst,
  parity_splitter_if.slave  bus
);

  localparam int NCHUNK = chunk_count(DATA_W, CHUNK_W);
  localparam int IDX_W  = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);

  generate
    if ((DATA_W % CHUNK_W) != 0 || NCHUNK < 2) begin : g_bad_params
      $error("parity_splitter: DATA_W must be a multiple of CHUNK_W with at least two chunks");
    end
  endgenerate

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [IDX_W-1:0]    idx;
  logic                done_pulse;

  logic [CHUNK_W-1:0]  head;
  logic [DATA_W-1:0]   shifted;
  logic                parity;
  logic                sending;
  logic                last;

  // The chunk to send always sits at the end of the register that leaves first.
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign head    = shreg[CHUNK_W-1:0];
      assign shifted = shreg >> CHUNK_W;
    end else begin : g_msb_first
      assign head    = shreg[DATA_W-1 -: CHUNK_W];
      assign shifted = shreg << CHUNK_W;
    end
  endgenerate

  parity_chunk #(.CHUNK_W(CHUNK_W)) u_parity (
    .data       (head),
    .odd_parity (ODD_PARITY != 0),
    .parity     (parity)
  );

  assign sending       = (state == SEND);
  assign last          = sending && (idx == IDX_W'(NCHUNK - 1));
  assign bus.out_valid = sending;
  assign bus.out_last  = last;
  assign bus.out_idx   = idx;
  assign bus.out_data  = sending ? {parity, head} : '0;
  assign bus.done      = done_pulse;
  // Accepting on the last-chunk handshake lets words stream without a bubble.
  assign bus.in_ready  = (state == IDLE) || (last && bus.out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shreg <= bus.in_data;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (last) begin
              done_pulse <= 1'b1;
              idx        <= '0;
              if (bus.in_valid) begin
                shreg <= bus.in_data;
              end else begin
                shreg <= shifted;
                state <= IDLE;
              end
            end else begin
              shreg <= shifted;
              idx   <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parity_splitter.sv
// Drives four parameter variants of the splitter in lockstep and checks them against a word-queue model.
`default_nettype none

module tb_parity_splitter;

  localparam int NINST = 4;
  localparam int NCH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic [8:0]  o_data  [NINST];
  logic [1:0]  o_idx   [NINST];
  logic        o_valid [NINST];
  logic        o_ready [NINST];
  logic        o_last  [NINST];
  logic        o_done  [NINST];

  always #5 clk = ~clk;

  // Instance p: odd parity when p is odd, LSB-first when p >= 2.
  generate
    for (genvar g = 0; g < NINST; g++) begin : g_dut
      parity_splitter_if #(.DATA_W(32), .CHUNK_W(8)) bus ();
      assign bus.in_data   = in_data;
      assign bus.in_valid  = in_valid;
      assign bus.out_ready = out_ready;
      assign o_data[g]  = bus.out_data;
      assign o_idx[g]   = bus.out_idx;
      assign o_valid[g] = bus.out_valid;
      assign o_ready[g] = bus.in_ready;
      assign o_last[g]  = bus.out_last;
      assign o_done[g]  = bus.done;
      parity_splitter #(
        .DATA_W(32), .CHUNK_W(8), .ODD_PARITY(g % 2), .LSB_FIRST(g / 2)
      ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  int n_pass  = 0;
  int n_total = 0;
  int done_count = 0;

  logic [31:0] words[$];
  int          beat     = 0;
  logic        done_exp = 1'b0;

  task automatic chk(input string tag, input int p, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, p, obs, exp);
  endtask

  function automatic logic [8:0] exp_chunk(input int p, input logic [31:0] w, input int b);
    int         pos;
    logic [7:0] c;
    pos = (p >= 2) ? b : (NCH - 1 - b);
    c   = 8'(w >> (8 * pos));
    return {(^c) ^ (p % 2 == 1), c};
  endfunction

  task automatic cycle();
    logic ev, er, el, hs_out;
    @(negedge clk);
    ev = (words.size() > 0);
    el = ev && (beat == NCH - 1);
    er = !ev || (el && out_ready);
    for (int p = 0; p < NINST; p++) begin
      chk("out_valid", p, 32'(o_valid[p]), 32'(ev));
      chk("in_ready",  p, 32'(o_ready[p]), 32'(er));
      chk("out_idx",   p, 32'(o_idx[p]),   32'(beat));
      chk("out_last",  p, 32'(o_last[p]),  32'(el));
      chk("done",      p, 32'(o_done[p]),  32'(done_exp));
      if (ev) chk("out_data", p, 32'(o_data[p]), 32'(exp_chunk(p, words[0], beat)));
    end
    if (o_done[0]) done_count++;
    hs_out   = ev && out_ready;
    done_exp = hs_out && el;
    if (hs_out) begin
      if (el) begin
        void'(words.pop_front());
        beat = 0;
      end else begin
        beat++;
      end
    end
    if (in_valid && er) words.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #2;
    for (int p = 0; p < NINST; p++) begin
      chk("rst_out_valid", p, 32'(o_valid[p]), 32'd0);
      chk("rst_out_data",  p, 32'(o_data[p]),  32'd0);
      chk("rst_out_idx",   p, 32'(o_idx[p]),   32'd0);
      chk("rst_out_last",  p, 32'(o_last[p]),  32'd0);
      chk("rst_done",      p, 32'(o_done[p]),  32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word, free-flowing output.
    in_data = 32'h12345678; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    idle_cycles(6);

    // Backpressure while chunk 1 is presented, with a competing word offered.
    in_data = 32'h12345678; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_data = 32'hDEADBEEF;
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("bp_hold_data", 0, 32'(o_data[0]), 32'h134);
    chk("bp_hold_idx",  0, 32'(o_idx[0]),  32'd1);
    idle_cycles(5);

    // Back-to-back words with no idle beat between them.
    done_count = 0;
    in_data = 32'h12345678; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_data = 32'hFFFF0000;
    for (int i = 0; i < 4; i++) cycle();
    idle_cycles(6);
    chk("b2b_done_pulses", 0, 32'(done_count), 32'd2);

    // Reset in the middle of a word.
    in_data = 32'h12345678; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    for (int p = 0; p < NINST; p++) begin
      chk("mid_rst_out_valid", p, 32'(o_valid[p]), 32'd0);
      chk("mid_rst_out_data",  p, 32'(o_data[p]),  32'd0);
      chk("mid_rst_out_idx",   p, 32'(o_idx[p]),   32'd0);
      chk("mid_rst_out_last",  p, 32'(o_last[p]),  32'd0);
      chk("mid_rst_done",      p, 32'(o_done[p]),  32'd0);
    end
    words.delete();
    beat     = 0;
    done_exp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    in_data = 32'hA5A5A5A5; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    chk("post_rst_first", 0, 32'(o_data[0]), 32'h0A5);
    idle_cycles(6);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_data   = $urandom;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
